// File: rtl/can_crc_engine.sv
// rtl/can_crc_engine.sv - parametrised MSB-first CRC engine with message framing and residue check
module can_crc_engine #(
    parameter int                 CRC_W   = 15,
    parameter logic [CRC_W-1:0]   POLY    = CRC_W'(15'h4599),
    parameter logic [CRC_W-1:0]   INIT    = '0,
    parameter logic [CRC_W-1:0]   XOR_OUT = '0,
    parameter logic [CRC_W-1:0]   RESIDUE = '0,
    parameter int                 DIN_W   = 1,
    parameter int                 CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] din,
    input  logic             din_last,
    output logic             busy,
    output logic             done,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_ok,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             seq_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CRC_W-1:0] crc_reg, crc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             seq_err_next;
    logic [CNT_W:0]   cnt_sum;

    // Unrolled serial LFSR: din[DIN_W-1] enters first, so a wide beat equals DIN_W serial beats.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] seed,
                                                  input logic [DIN_W-1:0] bits);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = seed;
        for (int i = DIN_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ bits[i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    assign cnt_sum = {1'b0, bit_cnt} + (CNT_W+1)'(DIN_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            crc_reg <= INIT;
            bit_cnt <= '0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_next;
            crc_reg <= crc_next;
            bit_cnt <= cnt_next;
            seq_err <= seq_err_next;
        end
    end

    // Priority: abort > start > din_valid; din_last only matters alongside din_valid.
    always_comb begin
        state_next   = state;
        crc_next     = crc_reg;
        cnt_next     = bit_cnt;
        seq_err_next = 1'b0;
        if (abort) begin
            state_next = IDLE;
            crc_next   = INIT;
        end else if (start) begin
            state_next = RUN;
            crc_next   = INIT;
            cnt_next   = '0;
            if (din_valid) begin
                crc_next = crc_step(INIT, din);
                cnt_next = CNT_W'(DIN_W);
                if (din_last) begin
                    state_next = DONE;
                end
            end
        end else if (din_valid) begin
            if (state == RUN) begin
                crc_next = crc_step(crc_reg, din);
                cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
                if (din_last) begin
                    state_next = DONE;
                end
            end else begin
                seq_err_next = 1'b1;
            end
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign crc_out = crc_reg ^ XOR_OUT;
    assign crc_ok  = done && (crc_reg == RESIDUE);

endmodule

// File: tb/tb_can_crc_engine.sv
// tb/tb_can_crc_engine.sv - directed self-checking bench for can_crc_engine
module tb_can_crc_engine;

    logic        clk = 1'b0;
    logic        rst, start, abort, din_valid, din, din_last;
    logic        busy, done, crc_ok, seq_err;
    logic [14:0] crc_out;
    logic [15:0] bit_cnt;

    logic        p_start, p_abort, p_valid, p_last;
    logic [7:0]  p_din;
    logic        p_busy, p_done, p_crc_ok, p_seq_err;
    logic [14:0] p_crc_out;
    logic [15:0] p_bit_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    can_crc_engine dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .din_valid(din_valid),
        .din(din), .din_last(din_last), .busy(busy), .done(done), .crc_out(crc_out),
        .crc_ok(crc_ok), .bit_cnt(bit_cnt), .seq_err(seq_err)
    );

    can_crc_engine #(.DIN_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(p_start), .abort(p_abort), .din_valid(p_valid),
        .din(p_din), .din_last(p_last), .busy(p_busy), .done(p_done), .crc_out(p_crc_out),
        .crc_ok(p_crc_ok), .bit_cnt(p_bit_cnt), .seq_err(p_seq_err)
    );

    function automatic logic [14:0] model_bit(input logic [14:0] c, input logic b);
        logic fb;
        fb = c[14] ^ b;
        c  = {c[13:0], 1'b0};
        if (fb) c = c ^ 15'h4599;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; din_valid = 0; din = 0; din_last = 0;
        p_start = 0; p_abort = 0; p_valid = 0; p_din = 0; p_last = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        tests_run++;
        if ({busy, done, crc_ok, seq_err, crc_out, bit_cnt} !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset: busy=%b done=%b ok=%b seq=%b crc=%h cnt=%0d, want all zero",
                     busy, done, crc_ok, seq_err, crc_out, bit_cnt);
        end
    endtask

    task automatic test_single_beat();
        start = 1; din_valid = 1; din = 1; din_last = 1;
        tick();
        idle_inputs();
        tests_run++;
        if (done !== 1 || busy !== 0 || crc_out !== 15'h4599 || bit_cnt !== 16'd1 || crc_ok !== 0) begin
            tests_failed++;
            $display("FAIL single_beat: done=%b busy=%b crc=%h cnt=%0d ok=%b, want 1 0 4599 1 0",
                     done, busy, crc_out, bit_cnt, crc_ok);
        end
        tick(); tick();
        tests_run++;
        if (done !== 1 || crc_out !== 15'h4599 || bit_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL done_hold: done=%b crc=%h cnt=%0d, want 1 4599 1", done, crc_out, bit_cnt);
        end
    endtask

    task automatic test_two_beat(input int gap);
        start = 1; din_valid = 1; din = 1;
        tick();
        idle_inputs();
        tests_run++;
        if (busy !== 1 || done !== 0 || crc_out !== 15'h4599 || bit_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL two_beat_first(gap=%0d): busy=%b done=%b crc=%h cnt=%0d, want 1 0 4599 1",
                     gap, busy, done, crc_out, bit_cnt);
        end
        for (int i = 0; i < gap; i++) tick();
        tests_run++;
        if (busy !== 1 || crc_out !== 15'h4599 || bit_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL gap_hold(gap=%0d): busy=%b crc=%h cnt=%0d, want 1 4599 1",
                     gap, busy, crc_out, bit_cnt);
        end
        din_valid = 1; din = 0; din_last = 1;
        tick();
        idle_inputs();
        tests_run++;
        if (done !== 1 || busy !== 0 || crc_out !== 15'h4EAB || bit_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL two_beat(gap=%0d): done=%b busy=%b crc=%h cnt=%0d, want 1 0 4eab 2",
                     gap, done, busy, crc_out, bit_cnt);
        end
    endtask

    task automatic test_residue();
        logic [14:0] r;
        r = 15'h4599;
        start = 1; din_valid = 1; din = 1;
        tick();
        start = 0;
        for (int i = 14; i >= 0; i--) begin
            din = r[i];
            din_last = (i == 0);
            tick();
        end
        idle_inputs();
        tests_run++;
        if (crc_out !== 15'h0000 || crc_ok !== 1 || done !== 1 || bit_cnt !== 16'd16) begin
            tests_failed++;
            $display("FAIL residue: crc=%h ok=%b done=%b cnt=%0d, want 0000 1 1 16",
                     crc_out, crc_ok, done, bit_cnt);
        end
    endtask

    task automatic test_wide();
        logic [7:0]  bytes [64];
        logic [14:0] model;
        model = 15'h0;
        for (int i = 0; i < 64; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            for (int j = 7; j >= 0; j--) model = model_bit(model, bytes[i][j]);
        end
        for (int i = 0; i < 64; i++) begin
            for (int j = 7; j >= 0; j--) begin
                start = (i == 0 && j == 7);
                din_valid = 1; din = bytes[i][j];
                din_last = (i == 63 && j == 0);
                p_start = (i == 0 && j == 7);
                p_valid = (j == 7); p_din = bytes[i];
                p_last = (i == 63 && j == 7);
                tick();
            end
        end
        idle_inputs();
        tests_run++;
        if (crc_out !== model || bit_cnt !== 16'd512 || done !== 1) begin
            tests_failed++;
            $display("FAIL wide_serial: crc=%h cnt=%0d done=%b, want %h 512 1", crc_out, bit_cnt, done, model);
        end
        tests_run++;
        if (p_crc_out !== model || p_bit_cnt !== 16'd512 || p_done !== 1) begin
            tests_failed++;
            $display("FAIL wide_byte: crc=%h cnt=%0d done=%b, want %h 512 1", p_crc_out, p_bit_cnt, p_done, model);
        end
    endtask

    task automatic test_abort();
        start = 1; din_valid = 1; din = 1;
        tick();
        start = 0; din = 0;
        tick();
        abort = 1; din = 1;
        tick();
        idle_inputs();
        tests_run++;
        if (busy !== 0 || done !== 0 || crc_out !== 15'h0 || bit_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL abort: busy=%b done=%b crc=%h cnt=%0d, want 0 0 0000 2", busy, done, crc_out, bit_cnt);
        end
        start = 1; abort = 1; din_valid = 1; din = 1;
        tick();
        idle_inputs();
        tests_run++;
        if (busy !== 0 || done !== 0 || crc_out !== 15'h0 || bit_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL start_with_abort: busy=%b done=%b crc=%h cnt=%0d, want 0 0 0000 2",
                     busy, done, crc_out, bit_cnt);
        end
        test_two_beat(0);
    endtask

    task automatic test_seq_err();
        din_valid = 1; din = 1;
        tick();
        idle_inputs();
        tests_run++;
        if (seq_err !== 1 || crc_out !== 15'h4EAB || bit_cnt !== 16'd2 || done !== 1) begin
            tests_failed++;
            $display("FAIL seq_err_done: seq=%b crc=%h cnt=%0d done=%b, want 1 4eab 2 1",
                     seq_err, crc_out, bit_cnt, done);
        end
        tick();
        tests_run++;
        if (seq_err !== 0) begin
            tests_failed++;
            $display("FAIL seq_err_pulse: seq=%b, want 0", seq_err);
        end
        abort = 1;
        tick();
        abort = 0; din_valid = 1; din = 1;
        tick();
        idle_inputs();
        tests_run++;
        if (seq_err !== 1 || crc_out !== 15'h0 || busy !== 0 || bit_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL seq_err_idle: seq=%b crc=%h busy=%b cnt=%0d, want 1 0000 0 2",
                     seq_err, crc_out, busy, bit_cnt);
        end
    endtask

    task automatic test_rst_mid();
        start = 1; din_valid = 1; din = 1;
        tick();
        start = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        tests_run++;
        if ({busy, done, crc_ok, seq_err, crc_out, bit_cnt} !== 35'd0) begin
            tests_failed++;
            $display("FAIL rst_mid: busy=%b done=%b ok=%b seq=%b crc=%h cnt=%0d, want all zero",
                     busy, done, crc_ok, seq_err, crc_out, bit_cnt);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_beat();
        test_two_beat(0);
        test_two_beat(3);
        test_residue();
        test_wide();
        test_abort();
        test_seq_err();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/can_crc_engine.md
Name: can_crc_engine

Overview:
- Parametrised successor to the team's serial CAN CRC-15 calculator.
- Computes a non-reflected CRC of any width and polynomial, consuming DIN_W bits per cycle, MSB first.
- Adds explicit message framing (start/last/abort), a final XOR, a processed-bit counter and a residue check for receive-side validation.
- Sits between the bit-stream (de)stuffing logic and the CAN frame TX/RX controllers. With default parameters it reproduces the legacy CAN CRC-15 result.

Parameters:
- CRC_W, 15, CRC register width (2..32).
- POLY, 15'h4599, generator polynomial without the implicit x^CRC_W term, CRC_W bits wide.
- INIT, 0, seed loaded on start, CRC_W bits wide.
- XOR_OUT, 0, value XORed onto crc_reg to form crc_out.
- RESIDUE, 0, crc_reg value that signals a good frame when the received CRC has been fed through the engine.
- DIN_W, 1, bits consumed per accepted beat (1..CRC_W); din[DIN_W-1] is processed first.
- CNT_W, 16, width of the bit counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- start, in, 1, begin a new message; loads INIT as the seed.
- abort, in, 1, discard the current message and return to IDLE.
- din_valid, in, 1, din holds a beat to be absorbed.
- din, in, DIN_W, data bits, MSB first.
- din_last, in, 1, qualifies din_valid; marks the final beat of the message.
- busy, out, 1, high in RUN.
- done, out, 1, high in DONE.
- crc_out, out, CRC_W, crc_reg ^ XOR_OUT (combinational from the register).
- crc_ok, out, 1, done && (crc_reg == RESIDUE).
- bit_cnt, out, CNT_W, number of bits absorbed since the last start.
- seq_err, out, 1, one-cycle pulse when din_valid arrives outside a message.

Behaviour:
- Reset values:
  - state = IDLE; crc_reg = INIT, so crc_out = INIT ^ XOR_OUT.
  - bit_cnt = 0; busy = 0; done = 0; crc_ok = 0; seq_err = 0.
- States are IDLE, RUN and DONE. Priority each cycle: rst > abort > start > din_valid.
- Single-bit step, for bit b: fb = crc_reg[CRC_W-1] ^ b, then crc = (crc << 1) truncated to CRC_W bits, XOR POLY if fb. A beat applies DIN_W single-bit steps in one cycle, din[DIN_W-1] first. The result must be identical to DIN_W serial beats.
- abort, in any state:
  - state goes to IDLE and crc_reg goes to INIT.
  - bit_cnt holds its value.
  - Any din_valid in the same cycle is ignored.
- start, without abort, in any state:
  - crc_reg loads INIT, bit_cnt loads 0, state goes to RUN.
  - If din_valid is also high, the beat is absorbed in the same cycle using INIT as the seed: crc_reg = step(INIT, din) and bit_cnt = DIN_W.
  - If din_last is also high, state goes to DONE instead of RUN (single-beat message).
- RUN with din_valid:
  - crc_reg = step(crc_reg, din); bit_cnt += DIN_W, saturating at all-ones.
  - With din_last, the update still happens and state goes to DONE on the next edge. done and crc_ok become valid in the cycle after the last beat, so latency is 1 cycle.
- RUN without din_valid: everything holds; gaps of any length are allowed.
- din_valid in IDLE or DONE without start:
  - The data is ignored; crc_reg and bit_cnt hold.
  - seq_err pulses for one cycle.
- DONE holds crc_out, crc_ok and bit_cnt stable until start, abort or rst.
- din_last without din_valid has no effect.
- rst in mid-message returns the block to reset values on the next edge; no partial result is retained.

Test Plan:
- Defaults, rst, then start with din_valid, din=1 and din_last together -> next cycle done=1, crc_out=0x4599, bit_cnt=1, crc_ok=0.
- Defaults: start with din=1, then din=0 with din_last -> crc_out=0x4EAB, bit_cnt=2. Insert a 3-cycle din_valid gap between the two beats -> same result.
- Residue: start, din=1, then the 15 bits of 0x4599 MSB first, the last one with din_last -> crc_reg=0, crc_ok=1, bit_cnt=16.
- DIN_W=8 instance against a DIN_W=1 instance, both fed 64 random bytes (the serial instance fed MSB-first) -> identical crc_out; bit_cnt=512 on both.
- Abort and start: abort mid-message -> IDLE, crc_out=INIT, busy=0. start together with abort -> IDLE. A later start restarts cleanly with the expected CRC.
- Sequencing: din_valid in IDLE -> seq_err pulses for 1 cycle and crc_out is unchanged. rst asserted in RUN -> all outputs at their reset values in the following cycle.
